// File: rtl/pll_da_ctrl_if.sv
// Signal bundle between the PLL dynamic-adjust controller, its requester and the PLL pins.
// The controller takes the slave side; the requester/PLL model takes the master side.
interface pll_da_ctrl_if;
  logic       cfg_req;
  logic [6:0] cfg_odiv;
  logic [6:0] cfg_mdiv;
  logic       cfg_ack;
  logic       pll_lock;
  logic       pll_reset;
  logic       pll_pwd;
  logic [6:0] odsel0;
  logic [6:0] mdsel;
  logic       clk_en;
  logic       ready;
  logic       busy;
  logic       cfg_err;
  logic [1:0] retry_cnt;

  modport master (
    output cfg_req, cfg_odiv, cfg_mdiv, pll_lock,
    input  cfg_ack, pll_reset, pll_pwd, odsel0, mdsel, clk_en, ready, busy, cfg_err, retry_cnt
  );

  modport slave (
    input  cfg_req, cfg_odiv, cfg_mdiv, pll_lock,
    output cfg_ack, pll_reset, pll_pwd, odsel0, mdsel, clk_en, ready, busy, cfg_err, retry_cnt
  );
endinterface

// File: rtl/pll_da_ctrl.sv
// PLL dynamic-adjust controller: gates the PLL output, applies new divider values,
// pulses PLL reset, waits for a stable lock with timeout/retry, and tracks lock loss.
module pll_da_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 64,
  parameter int LOCK_WAIT     = 50000,
  parameter int MAX_RETRY     = 3,
  parameter int GATE_CYCLES   = 4,
  parameter int DEF_ODIV      = 5,
  parameter int DEF_MDIV      = 21
) (
  input logic          clk,
  input logic          rst,
  pll_da_ctrl_if.slave ctrl
);

  localparam int PH_MAX = (RST_CYCLES > GATE_CYCLES) ? RST_CYCLES : GATE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int ST_W   = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W   = $clog2(LOCK_WAIT + 1);

  typedef enum logic [2:0] {GATE, APPLY, WAIT_LOCK, UNGATE, RUN, FAULT} state_e;

  state_e          state_q, state_d;
  logic [PH_W-1:0] phaseCnt_q;
  logic [ST_W-1:0] stableCnt_q;
  logic [TO_W-1:0] timeoutCnt_q;
  logic [1:0]      retryCnt_q;
  logic            lkMeta_q, lk_q, lkLow_q;
  logic [6:0]      pendOdiv_q, pendMdiv_q;
  logic [6:0]      odsel_q, mdsel_q;
  logic            cfgErr_q;
  logic            ackPulse;
  logic            lockLoss;

  // A zero divider is illegal for the PLL, so it is promoted to 1.
  function automatic logic [6:0] nonZero(input logic [6:0] v);
    return (v == 7'd0) ? 7'd1 : v;
  endfunction

  assign lockLoss = (state_q == RUN) && !lk_q && lkLow_q;

  always_comb begin
    state_d  = state_q;
    ackPulse = 1'b0;
    unique case (state_q)
      GATE:      if (phaseCnt_q == PH_W'(GATE_CYCLES - 1)) state_d = APPLY;
      APPLY:     if (phaseCnt_q == PH_W'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (stableCnt_q == ST_W'(STABLE_CYCLES))
          state_d = UNGATE;
        else if (timeoutCnt_q == TO_W'(LOCK_WAIT))
          state_d = (int'(retryCnt_q) < MAX_RETRY) ? APPLY : FAULT;
      end
      UNGATE:    state_d = RUN;
      RUN: begin
        if (lockLoss) begin
          state_d = APPLY;
        end else if (ctrl.cfg_req) begin
          ackPulse = 1'b1;
          state_d  = GATE;
        end
      end
      FAULT: begin
        if (ctrl.cfg_req) begin
          ackPulse = 1'b1;
          state_d  = GATE;
        end
      end
      default:   state_d = APPLY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= APPLY;
      phaseCnt_q   <= '0;
      stableCnt_q  <= '0;
      timeoutCnt_q <= '0;
      retryCnt_q   <= '0;
      lkMeta_q     <= 1'b0;
      lk_q         <= 1'b0;
      lkLow_q      <= 1'b0;
      pendOdiv_q   <= 7'(DEF_ODIV);
      pendMdiv_q   <= 7'(DEF_MDIV);
      odsel_q      <= 7'(DEF_ODIV);
      mdsel_q      <= 7'(DEF_MDIV);
      cfgErr_q     <= 1'b0;
    end else begin
      lkMeta_q <= ctrl.pll_lock;
      lk_q     <= lkMeta_q;
      lkLow_q  <= (state_q == RUN) && !lk_q;
      state_q  <= state_d;
      cfgErr_q <= (state_d == FAULT) && (state_q != FAULT);

      // Every state starts its counters from zero; all counters saturate.
      if (state_d != state_q) begin
        phaseCnt_q   <= '0;
        stableCnt_q  <= '0;
        timeoutCnt_q <= '0;
      end else begin
        if (phaseCnt_q != '1) phaseCnt_q <= phaseCnt_q + 1'b1;
        if (state_q == WAIT_LOCK) begin
          if (!lk_q)                    stableCnt_q  <= '0;
          else if (stableCnt_q != '1)   stableCnt_q  <= stableCnt_q + 1'b1;
          if (timeoutCnt_q != '1)       timeoutCnt_q <= timeoutCnt_q + 1'b1;
        end
      end

      if (state_q == APPLY && phaseCnt_q == '0) begin
        odsel_q <= nonZero(pendOdiv_q);
        mdsel_q <= nonZero(pendMdiv_q);
      end

      if (ackPulse) begin
        pendOdiv_q <= ctrl.cfg_odiv;
        pendMdiv_q <= ctrl.cfg_mdiv;
      end

      if (ackPulse || lockLoss || state_d == RUN)
        retryCnt_q <= '0;
      else if (state_q == WAIT_LOCK && state_d == APPLY && retryCnt_q != 2'b11)
        retryCnt_q <= retryCnt_q + 1'b1;
    end
  end

  assign ctrl.cfg_ack   = ackPulse;
  assign ctrl.pll_reset = (state_q == APPLY);
  assign ctrl.pll_pwd   = (state_q == FAULT);
  assign ctrl.clk_en    = (state_q == UNGATE) || (state_q == RUN);
  assign ctrl.ready     = (state_q == RUN);
  assign ctrl.busy      = (state_q != RUN) && (state_q != FAULT);
  assign ctrl.cfg_err   = cfgErr_q;
  assign ctrl.retry_cnt = retryCnt_q;
  assign ctrl.odsel0    = odsel_q;
  assign ctrl.mdsel     = mdsel_q;

endmodule

// File: tb/tb_pll_da_ctrl.sv
// Directed bench for pll_da_ctrl: power-up, reconfiguration, lock glitch,
// lock loss, timeout into FAULT, and reset in the middle of a reconfiguration.
module tb_pll_da_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pll_da_ctrl_if bus ();

  pll_da_ctrl #(
    .RST_CYCLES(4), .STABLE_CYCLES(8), .LOCK_WAIT(100), .MAX_RETRY(2), .GATE_CYCLES(4),
    .DEF_ODIV(5), .DEF_MDIV(21)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic req, input logic [6:0] odiv, input logic [6:0] mdiv);
    bus.cfg_req  = req;
    bus.cfg_odiv = odiv;
    bus.cfg_mdiv = mdiv;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rstHigh, readyK, gateLow, ackCnt, pulses, errCnt, ackK;
    logic prevReset, seenRst, seen1, seen2, ackReady;
    logic [6:0] ackOdsel;

    rst = 1'b1;
    bus.pll_lock = 1'b1;
    applyStimulus(1'b0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);

    checkOutput("rst_pll_reset", bus.pll_reset, 1);
    checkOutput("rst_pll_pwd",   bus.pll_pwd,   0);
    checkOutput("rst_clk_en",    bus.clk_en,    0);
    checkOutput("rst_ready",     bus.ready,     0);
    checkOutput("rst_busy",      bus.busy,      1);
    checkOutput("rst_cfg_ack",   bus.cfg_ack,   0);
    checkOutput("rst_cfg_err",   bus.cfg_err,   0);
    checkOutput("rst_retry",     bus.retry_cnt, 0);
    checkOutput("rst_odsel0",    bus.odsel0,    5);
    checkOutput("rst_mdsel",     bus.mdsel,     21);

    // Power-up: reset pulse of 4 cycles, ready around release+15.
    rst = 1'b0;
    #1;
    rstHigh = bus.pll_reset ? 1 : 0;
    readyK  = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.pll_reset) rstHigh++;
      if (bus.ready && readyK < 0) readyK = k;
    end
    checkOutput("pwrup_reset_cycles", rstHigh, 4);
    checkOutput("pwrup_ready_window", (readyK >= 14 && readyK <= 16) ? 1 : 0, 1);
    checkOutput("pwrup_odsel0",       bus.odsel0, 5);
    checkOutput("pwrup_mdsel",        bus.mdsel, 21);
    checkOutput("pwrup_busy",         bus.busy, 0);
    checkOutput("pwrup_clk_en",       bus.clk_en, 1);

    // Reconfiguration to 10/30.
    applyStimulus(1'b1, 7'd10, 7'd30);
    #1;
    checkOutput("reconf_ack", bus.cfg_ack, 1);
    ackCnt = bus.cfg_ack ? 1 : 0;
    @(negedge clk);
    checkOutput("reconf_ack_ignored_gate", bus.cfg_ack, 0);
    applyStimulus(1'b0, 7'd0, 7'd0);
    gateLow = (!bus.clk_en && !bus.pll_reset) ? 1 : 0;
    seenRst = 1'b0;
    readyK  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.pll_reset) seenRst = 1'b1;
      if (!seenRst && !bus.clk_en) gateLow++;
      if (bus.cfg_ack) ackCnt++;
      if (bus.ready && readyK < 0) readyK = k;
    end
    checkOutput("reconf_gate_cycles", (gateLow >= 4) ? 1 : 0, 1);
    checkOutput("reconf_ack_count",   ackCnt, 1);
    checkOutput("reconf_ready_window", (readyK >= 17 && readyK <= 19) ? 1 : 0, 1);
    checkOutput("reconf_odsel0",      bus.odsel0, 10);
    checkOutput("reconf_mdsel",       bus.mdsel, 30);

    // Reconfigure to 0/0 (promoted to 1/1) with a one-cycle lk glitch at stable count 7.
    applyStimulus(1'b1, 7'd0, 7'd0);
    #1;
    checkOutput("glitch_ack", bus.cfg_ack, 1);
    @(negedge clk);
    applyStimulus(1'b0, 7'd0, 7'd0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 13) bus.pll_lock = 1'b0;
      if (k == 14) bus.pll_lock = 1'b1;
      if (k == 7)  checkOutput("glitch_apply_end", bus.pll_reset, 1);
      if (k == 8)  checkOutput("glitch_wait_lock", bus.pll_reset, 0);
      if (k == 25) checkOutput("glitch_not_ready", bus.ready, 0);
      if (k == 26) checkOutput("glitch_ready",     bus.ready, 1);
    end
    checkOutput("zero_odsel0", bus.odsel0, 1);
    checkOutput("zero_mdsel",  bus.mdsel, 1);

    // Lock loss in RUN coinciding with cfg_req: relock, no ack, settings unchanged.
    bus.pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("loss_single_low_ok", bus.ready, 1);
    @(negedge clk);
    applyStimulus(1'b1, 7'd50, 7'd60);
    #1;
    checkOutput("loss_no_ack", bus.cfg_ack, 0);
    bus.pll_lock = 1'b1;
    ackCnt = 0;
    readyK = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) checkOutput("loss_ready_drop", bus.ready, 0);
      if (k == 1) checkOutput("loss_clk_en_drop", bus.clk_en, 0);
      if (bus.cfg_ack) ackCnt++;
      if (k == 8) applyStimulus(1'b0, 7'd0, 7'd0);
      if (bus.ready && readyK < 0) readyK = k;
    end
    checkOutput("loss_ack_count", ackCnt, 0);
    checkOutput("loss_relocked", (readyK > 0) ? 1 : 0, 1);
    checkOutput("loss_odsel0", bus.odsel0, 1);
    checkOutput("loss_mdsel",  bus.mdsel, 1);

    // Timeout: lock never returns, three attempts then FAULT.
    bus.pll_lock = 1'b0;
    prevReset = bus.pll_reset;
    pulses = 0;
    errCnt = 0;
    seen1  = 1'b0;
    seen2  = 1'b0;
    for (int k = 1; k <= 450; k++) begin
      @(negedge clk);
      if (bus.pll_reset && !prevReset) pulses++;
      prevReset = bus.pll_reset;
      if (bus.cfg_err) errCnt++;
      if (bus.retry_cnt == 2'd1) seen1 = 1'b1;
      if (bus.retry_cnt == 2'd2 && seen1) seen2 = 1'b1;
    end
    checkOutput("to_apply_pulses", pulses, 3);
    checkOutput("to_retry_1",      seen1, 1);
    checkOutput("to_retry_2",      seen2, 1);
    checkOutput("to_cfg_err_once", errCnt, 1);
    checkOutput("to_pll_pwd",      bus.pll_pwd, 1);
    checkOutput("to_busy",         bus.busy, 0);
    checkOutput("to_ready",        bus.ready, 0);
    checkOutput("to_clk_en",       bus.clk_en, 0);

    // Reconfiguration out of FAULT, then reset during its APPLY phase.
    bus.pll_lock = 1'b1;
    applyStimulus(1'b1, 7'd10, 7'd30);
    #1;
    checkOutput("fault_ack", bus.cfg_ack, 1);
    @(negedge clk);
    checkOutput("fault_pwd_release", bus.pll_pwd, 0);
    applyStimulus(1'b0, 7'd0, 7'd0);
    repeat (5) @(negedge clk);
    checkOutput("mid_apply_odsel0", bus.odsel0, 10);
    checkOutput("mid_apply_mdsel",  bus.mdsel, 30);
    rst = 1'b1;
    applyStimulus(1'b1, 7'd40, 7'd41);
    @(negedge clk);
    checkOutput("midrst_odsel0", bus.odsel0, 5);
    checkOutput("midrst_mdsel",  bus.mdsel, 21);
    checkOutput("midrst_pll_reset", bus.pll_reset, 1);
    checkOutput("midrst_no_ack", bus.cfg_ack, 0);
    rst = 1'b0;
    ackK     = -1;
    ackReady = 1'b0;
    ackOdsel = 7'd0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.cfg_ack) begin
        ackK     = k;
        ackReady = bus.ready;
        ackOdsel = bus.odsel0;
        break;
      end
    end
    checkOutput("midrst_ack_seen",   (ackK > 0) ? 1 : 0, 1);
    checkOutput("midrst_ack_in_run", ackReady, 1);
    checkOutput("midrst_defaults",   ackOdsel, 5);
    applyStimulus(1'b0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_da_ctrl.md
PLL_DA_CTRL -- requirements
Module: pll_da_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles pll_reset is held high per (re)lock attempt.
REQ-002 SHALL have parameter STABLE_CYCLES, default 64: number of consecutive synchronized-lock cycles required before the PLL counts as locked.
REQ-003 SHALL have parameter LOCK_WAIT, default 50000: cycle budget per attempt before timeout.
REQ-004 SHALL have parameter MAX_RETRY, default 3: maximum number of retries after the first attempt.
REQ-005 SHALL have parameter GATE_CYCLES, default 4: number of cycles clk_en is held low before reconfiguration starts.
REQ-006 SHALL have parameters DEF_ODIV, default 5, and DEF_MDIV, default 21: divider values applied out of reset.
REQ-007 SHALL have port clk, input, width 1: system clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, width 1: reset; synchronous and active-high.
REQ-009 SHALL have port cfg_req, input, width 1: reconfiguration request, level-sensitive, held until cfg_ack.
REQ-010 SHALL have port cfg_odiv, input, width 7: requested ODIV0 value; sampled when cfg_req is accepted.
REQ-011 SHALL have port cfg_mdiv, input, width 7: requested MDIV value; sampled when cfg_req is accepted.
REQ-012 SHALL have port cfg_ack, output, width 1: one-cycle pulse when a request is accepted.
REQ-013 SHALL have port pll_lock, input, width 1: raw PLL LOCK, asynchronous to clk.
REQ-014 SHALL have port pll_reset, output, width 1: drives the PLL RESET pin.
REQ-015 SHALL have port pll_pwd, output, width 1: drives the PLL PLLPWD pin.
REQ-016 SHALL have port odsel0, output, width 7: drives the dynamic ODSEL0 pins.
REQ-017 SHALL have port mdsel, output, width 7: drives the dynamic MDSEL pins.
REQ-018 SHALL have port clk_en, output, width 1: drives ENCLK0.
REQ-019 SHALL have port ready, output, width 1: high when the PLL is locked and its output is ungated.
REQ-020 SHALL have port busy, output, width 1: high in every state other than RUN and FAULT.
REQ-021 SHALL have port cfg_err, output, width 1: one-cycle pulse on entry to FAULT.
REQ-022 SHALL have port retry_cnt, output, width 2: number of retries used in the current sequence.

Function
REQ-023 SHALL pass pll_lock through a 2-flop synchronizer; all lock decisions use the synchronized signal lk.
REQ-024 SHALL implement the states GATE, APPLY, WAIT_LOCK, UNGATE, RUN and FAULT.
REQ-025 GATE: clk_en=0 for GATE_CYCLES cycles, then go to APPLY.
REQ-026 APPLY: load odsel0/mdsel from the pending values on the first cycle; hold pll_reset=1 for RST_CYCLES cycles; then go to WAIT_LOCK.
REQ-027 WAIT_LOCK: pll_reset=0; a stable counter increments while lk=1 and clears to 0 whenever lk=0; a timeout counter increments every cycle.
REQ-028 WAIT_LOCK: when the stable counter reaches STABLE_CYCLES, go to UNGATE; this check has priority over timeout in the same cycle.
REQ-029 WAIT_LOCK: when the timeout counter reaches LOCK_WAIT, increment retry_cnt and return to APPLY if retry_cnt<MAX_RETRY; otherwise go to FAULT.
REQ-030 UNGATE: clk_en=1 for one cycle, then go to RUN; retry_cnt clears on entry to RUN.
REQ-031 RUN: ready=1 and clk_en=1.
REQ-032 RUN: when cfg_req=1, pulse cfg_ack, latch cfg_odiv/cfg_mdiv as pending, and go to GATE.
REQ-033 RUN: when lk=0 for 2 consecutive cycles (lock loss), drop ready and clk_en and go to APPLY with unchanged settings; retry_cnt restarts at 0.
REQ-034 FAULT: pll_pwd=1, clk_en=0, ready=0.
REQ-035 FAULT: cfg_req is accepted exactly as in RUN (REQ-032), with pll_pwd released on the transition to GATE.
REQ-036 SHALL ignore cfg_req in every state other than RUN and FAULT: no cfg_ack, request stays pending at the requester.
REQ-037 If cfg_req and lock loss occur in the same RUN cycle, lock loss SHALL win and cfg_ack SHALL NOT pulse.
REQ-038 A pending value of 0 SHALL be replaced by 1 before being loaded into odsel0/mdsel.
REQ-039 All counters SHALL saturate and SHALL NOT wrap.

Reset
REQ-040 While rst=1, outputs SHALL be: pll_reset=1, pll_pwd=0, clk_en=0, ready=0, busy=1, cfg_ack=0, cfg_err=0, retry_cnt=0, odsel0=DEF_ODIV, mdsel=DEF_MDIV, pending=defaults, state=APPLY.
REQ-041 On release of rst, the block SHALL start the normal lock sequence from APPLY.
REQ-042 Asserting rst in any state, mid-sequence included, SHALL abort the sequence and discard any pending request.

Verification
(Parameters for all scenarios: RST_CYCLES=4, STABLE_CYCLES=8, LOCK_WAIT=100, MAX_RETRY=2, GATE_CYCLES=4.)
REQ-043 Power-up: release rst, pll_lock=1 from cycle 0 -> pll_reset high for 4 cycles, ready=1 at release+4+2+8+1 (±1 cycle), odsel0=5, mdsel=21.
REQ-044 Reconfig: in RUN, cfg_req with odiv=10, mdiv=30 -> one cfg_ack, clk_en=0 for at least 4 cycles before pll_reset rises, odsel0=10, mdsel=30, ready returns to 1.
REQ-045 Lock glitch: in WAIT_LOCK, lk low for 1 cycle at stable count 7 -> stable counter restarts; ready occurs 8 full lk cycles later.
REQ-046 Timeout: pll_lock held at 0 -> 3 APPLY pulses, retry_cnt goes 1 then 2, cfg_err pulses once, pll_pwd=1, busy=0.
REQ-047 Lock loss: in RUN, pll_lock low for 3 cycles with cfg_req high -> ready drops, no cfg_ack, relock with unchanged odsel0/mdsel.
REQ-048 Mid-reset: rst during APPLY of a reconfiguration -> defaults 5/21 restored; cfg_req ignored until RUN.
